des_key_rotator_seq: RTL and testbench

- Sequential, parametrised successor to the combinational C/D half-key rotator in the DES subkey path.
- Loads a C/D pair once, then emits one rotated C/D pair per round for ROUNDS rounds, with a valid/ready handshake.
- Supports encrypt (left-rotate) and decrypt (right-rotate) schedules, so PC-2 and the round core can consume subkeys in either order.
- Sits between PC-1 and PC-2 in the subkey generator.

---
 rtl/des_key_pkg.sv | 32 +++
 rtl/des_key_rotator_seq_half_rotate.sv | 33 +++
 rtl/des_key_rotator_seq.sv | 155 +++++++++++++++
 tb/tb_des_key_rotator_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_key_pkg.sv
// Shared definitions for the DES C/D half-key rotation path: default geometry,
// the standard shift schedule, FSM encoding and fixed-width rotate helpers.
package des_key_pkg;

    localparam int HALF_W_DEF = 28;
    localparam int ROUNDS_DEF = 16;

    // Bit r-1 set means round r rotates by two positions instead of one.
    localparam logic [15:0] DES_SHIFT_MAP = 16'h7EFC;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [HALF_W_DEF-1:0] rotl(
        input logic [HALF_W_DEF-1:0] x,
        input logic                  two
    );
        return two ? {x[HALF_W_DEF-3:0], x[HALF_W_DEF-1:HALF_W_DEF-2]}
                   : {x[HALF_W_DEF-2:0], x[HALF_W_DEF-1]};
    endfunction

    function automatic logic [HALF_W_DEF-1:0] rotr(
        input logic [HALF_W_DEF-1:0] x,
        input logic                  two
    );
        return two ? {x[1:0], x[HALF_W_DEF-1:2]}
                   : {x[0], x[HALF_W_DEF-1:1]};
    endfunction

endpackage

// File: rtl/des_key_rotator_seq_half_rotate.sv
// Combinational rotate of one key half by 1 or 2 positions, left or right.
// Pure wiring plus a 2:1 mux per direction; no barrel shifter.
module des_half_rotate
    import des_key_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF
) (
    input  logic [HALF_W-1:0] din,
    input  logic              dir_right,
    input  logic              two,
    output logic [HALF_W-1:0] dout
);

    logic [HALF_W-1:0] l_rot;
    logic [HALF_W-1:0] r_rot;

    generate
        if (HALF_W == HALF_W_DEF) begin : g_des_width
            assign l_rot = rotl(din, two);
            assign r_rot = rotr(din, two);
        end else begin : g_any_width
            for (genvar gi = 0; gi < HALF_W; gi++) begin : g_bit
                assign l_rot[gi] = two ? din[(gi + HALF_W - 2) % HALF_W]
                                       : din[(gi + HALF_W - 1) % HALF_W];
                assign r_rot[gi] = two ? din[(gi + 2) % HALF_W]
                                       : din[(gi + 1) % HALF_W];
            end
        end
    endgenerate

    assign dout = dir_right ? r_rot : l_rot;

endmodule

// File: rtl/des_key_rotator_seq.sv
// Sequential C/D rotator: loads a PC-1 key pair and emits one rotated pair per
// round under a valid/ready handshake, in encrypt or decrypt order.
module des_key_rotator_seq
    import des_key_pkg::*;
#(
    parameter int                HALF_W    = HALF_W_DEF,
    parameter int                ROUNDS    = ROUNDS_DEF,
    parameter logic [ROUNDS-1:0] SHIFT_MAP = ROUNDS'(DES_SHIFT_MAP),
    localparam int               RW        = $clog2(ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [HALF_W-1:0] left_in,
    input  logic [HALF_W-1:0] right_in,
    output logic              in_ready,
    output logic [HALF_W-1:0] left_out,
    output logic [HALF_W-1:0] right_out,
    output logic [RW-1:0]     round_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [HALF_W-1:0] c_q, c_d;
    logic [HALF_W-1:0] d_q, d_d;
    logic [RW-1:0]     round_q, round_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic [HALF_W-1:0] c_src, d_src;
    logic [HALF_W-1:0] c_rot, d_rot;
    logic              rot_dir_right;
    logic              rot_two;
    logic [RW-1:0]     amt_idx;
    logic              last_round;

    // In IDLE the rotators prepare the encrypt round-1 load from the inputs;
    // in RUN they prepare round r+1 from the held C/D registers.
    always_comb begin
        c_src         = left_in;
        d_src         = right_in;
        rot_dir_right = 1'b0;
        amt_idx       = '0;
        if (state_q == ST_RUN) begin
            c_src         = c_q;
            d_src         = d_q;
            rot_dir_right = mode_q;
            amt_idx       = mode_q ? (RW'(ROUNDS) - round_q) : round_q;
        end
    end

    always_comb begin
        rot_two = 1'b0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (amt_idx == RW'(i)) begin
                rot_two = SHIFT_MAP[i];
            end
        end
    end

    des_half_rotate #(
        .HALF_W (HALF_W)
    ) u_rot_c (
        .din       (c_src),
        .dir_right (rot_dir_right),
        .two       (rot_two),
        .dout      (c_rot)
    );

    des_half_rotate #(
        .HALF_W (HALF_W)
    ) u_rot_d (
        .din       (d_src),
        .dir_right (rot_dir_right),
        .two       (rot_two),
        .dout      (d_rot)
    );

    assign last_round = (round_q == RW'(ROUNDS));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    // Decrypt round 1 is C16/D16, which equals the unrotated C0/D0.
                    c_d     = mode ? left_in : c_rot;
                    d_d     = mode ? right_in : d_rot;
                    round_d = RW'(1);
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    if (last_round) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        c_d     = c_rot;
                        d_d     = d_rot;
                        round_d = round_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign left_out  = c_q;
    assign right_out = d_q;
    assign round_out = round_q;
    assign out_valid = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_des_key_rotator_seq.sv
// Scoreboard bench for des_key_rotator_seq: expected rounds are queued from a
// cumulative-shift reference model and checked by an independent monitor.
module tb_des_key_rotator_seq;

    localparam int          W   = 28;
    localparam int          R   = 16;
    localparam int          RWB = $clog2(R + 1);
    localparam logic [15:0] MAP = 16'h7EFC;

    typedef struct {
        int           rnd;
        logic [W-1:0] c;
        logic [W-1:0] d;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           mode;
    logic [W-1:0]   left_in;
    logic [W-1:0]   right_in;
    logic           in_ready;
    logic [W-1:0]   left_out;
    logic [W-1:0]   right_out;
    logic [RWB-1:0] round_out;
    logic           out_valid;
    logic           out_ready;
    logic           done;

    exp_t         q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           mon_en  = 0;
    bit           done_due = 0;
    int           rdy_mode = 0;
    int           bp_cnt   = 0;
    logic [W-1:0] obs_c[0:R];
    logic [W-1:0] obs_d[0:R];
    int           obs_cnt[0:R];

    des_key_rotator_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .left_in   (left_in),
        .right_in  (right_in),
        .in_ready  (in_ready),
        .left_out  (left_out),
        .right_out (right_out),
        .round_out (round_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int amt(int r);
        return MAP[r-1] ? 2 : 1;
    endfunction

    function automatic logic [W-1:0] rot(logic [W-1:0] x, int n, bit left);
        int m;
        m = n % W;
        if (m == 0) return x;
        return left ? ((x << m) | (x >> (W - m))) : ((x >> m) | (x << (W - m)));
    endfunction

    // Round k of encryption is C0 rotated left by the sum of amt(1..k);
    // round k of decryption is C0 rotated right by the sum of amt(R+2-j), j=2..k.
    task automatic push_schedule(logic [W-1:0] c0, logic [W-1:0] d0, bit m);
        int   s = 0;
        exp_t e;
        for (int k = 1; k <= R; k++) begin
            if (!m) s += amt(k);
            else if (k >= 2) s += amt(R + 2 - k);
            e.rnd = k;
            e.c   = rot(c0, s, !m);
            e.d   = rot(d0, s, !m);
            q.push_back(e);
        end
    endtask

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i <= R; i++) begin
            obs_c[i]   = '0;
            obs_d[i]   = '0;
            obs_cnt[i] = 0;
        end
    endtask

    task automatic start_key(logic [W-1:0] c0, logic [W-1:0] d0, bit m, bit expect_done_now);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL start_wait: in_ready stayed %b, required 1", in_ready);
        end
        if (expect_done_now) check("done_with_start", W'(done), W'(1));
        start    = 1'b1;
        mode     = m;
        left_in  = c0;
        right_in = d0;
        @(posedge clk); #1;
        start    = 1'b0;
        left_in  = $urandom();
        right_in = $urandom();
        mode     = $urandom_range(0, 1);
        push_schedule(c0, d0, m);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (q.size() != 0 || !in_ready) begin
            n_fail++;
            $display("FAIL idle_timeout: %0d rounds pending, in_ready %b", q.size(), in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_round(int r);
        int n = 0;
        while (!(out_valid && int'(round_out) == r) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_round", W'(round_out), W'(r));
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: out_ready = ($urandom_range(0, 9) < 7);
            2: begin
                if (out_valid && round_out == RWB'(5) && bp_cnt < 3) begin
                    out_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && mon_en) begin
            n_tests++;
            if (done !== done_due) begin
                n_fail++;
                $display("FAIL done: got %b expected %b", done, done_due);
            end
            done_due = 0;
            if (out_valid) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL in_ready_run: got %b expected 0", in_ready);
                end
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: round %0d C %h D %h", round_out, left_out, right_out);
                end else begin
                    e = q[0];
                    if (int'(round_out) != e.rnd || left_out !== e.c || right_out !== e.d) begin
                        n_fail++;
                        $display("FAIL round: got r%0d C %h D %h expected r%0d C %h D %h",
                                 round_out, left_out, right_out, e.rnd, e.c, e.d);
                    end
                    obs_cnt[e.rnd]++;
                    if (out_ready) begin
                        obs_c[e.rnd] = left_out;
                        obs_d[e.rnd] = right_out;
                        void'(q.pop_front());
                        if (e.rnd == R) done_due = 1;
                    end
                end
            end else if (q.size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL valid_low: out_valid 0 with round %0d pending", q[0].rnd);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        left_in   = '0;
        right_in  = '0;
        out_ready = 1'b1;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_ready", W'(in_ready), W'(1));
        check("rst_done", W'(done), W'(0));
        check("rst_round", W'(round_out), W'(0));
        check("rst_left", left_out, '0);
        check("rst_right", right_out, '0);
        mon_en = 1;

        // Directed encrypt, then a decrypt of the same key started in the done cycle.
        start_key(28'hF0CCAAF, 28'h556678F, 1'b0, 1'b0);
        wait_round(R);
        @(posedge clk); #1;
        check("enc_r1_c", obs_c[1], 28'hE19955F);
        check("enc_r1_d", obs_d[1], 28'hAACCF1E);
        check("enc_r2_c", obs_c[2], 28'hC332ABF);
        check("enc_r2_d", obs_d[2], 28'h5599E3D);
        check("enc_r3_c", obs_c[3], 28'h0CCAAFF);
        check("enc_r16_c", obs_c[16], 28'hF0CCAAF);
        check("enc_r16_d", obs_d[16], 28'h556678F);
        clear_obs();
        start_key(28'hF0CCAAF, 28'h556678F, 1'b1, 1'b1);
        check("b2b_valid", W'(out_valid), W'(1));
        check("b2b_round", W'(round_out), W'(1));
        wait_idle();
        check("dec_r1_c", obs_c[1], 28'hF0CCAAF);
        check("dec_r1_d", obs_d[1], 28'h556678F);
        check("dec_r2_c", obs_c[2], 28'hF866557);
        check("dec_r16_c", obs_c[16], 28'hE19955F);
        check("dec_r16_d", obs_d[16], 28'hAACCF1E);

        // Backpressure on round 5.
        clear_obs();
        bp_cnt   = 0;
        rdy_mode = 2;
        start_key($urandom(), $urandom(), 1'b0, 1'b0);
        wait_idle();
        rdy_mode = 0;
        check("bp_hold_cycles", W'(obs_cnt[5]), W'(4));
        check("bp_r6_once", W'(obs_cnt[6]), W'(1));

        // Start during RUN is ignored.
        start_key(28'h1234567, 28'h89ABCDE, 1'b0, 1'b0);
        wait_round(8);
        start    = 1'b1;
        mode     = 1'b1;
        left_in  = 28'hFFFFFFF;
        right_in = 28'h0000001;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Reset mid-schedule.
        start_key($urandom(), $urandom(), 1'b1, 1'b0);
        wait_round(10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        done_due = 0;
        check("mid_rst_valid", W'(out_valid), W'(0));
        check("mid_rst_ready", W'(in_ready), W'(1));
        check("mid_rst_round", W'(round_out), W'(0));
        check("mid_rst_done", W'(done), W'(0));
        @(posedge clk); #1;
        start_key(28'hF0CCAAF, 28'h556678F, 1'b0, 1'b0);
        wait_idle();

        // Randomized keys, modes and consumer stalls, issued back to back.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            start_key($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b0);
        end
        wait_idle();
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
